// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM and timing helpers for the HD44780 controller
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP,
      INIT_LD,
      SETUP,
      PULSE,
      HOLD,
      WAIT,
      IDLE
   } lcd_state_e;

   localparam logic [7:0] CMD_FUNCSET = 8'h38;

   localparam logic [7:0] LCD_INIT_CMD [6] = '{CMD_FUNCSET, CMD_FUNCSET, CMD_FUNCSET, 8'h0C, 8'h01, 8'h06};

   // Microseconds to clock cycles, rounded up so every wait meets its minimum
   function automatic int unsigned us2cyc(input int unsigned us, input int unsigned clk_hz);
      return 32'((64'(us) * 64'(clk_hz) + 64'd999_999) / 64'd1_000_000);
   endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_timer.sv
// lcd_wait_timer: load-and-count-down timer shared by every timed phase
module lcd_wait_timer #(
   parameter int unsigned     W       = 8,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;

   // Load wins; otherwise count down and park at zero
   always_comb begin
      cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
   end

   // Reset preloads the power-up wait so PWRUP needs no extra load cycle
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= RST_VAL;
      else     cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 init sequencer and timed byte-write engine
module lcd_hd44780_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 27_000_000,
   parameter int unsigned POWERUP_US    = 15000,
   parameter int unsigned INIT_WAIT_US  = 4100,
   parameter int unsigned SHORT_WAIT_US = 40,
   parameter int unsigned LONG_WAIT_US  = 1640,
   parameter int unsigned EN_SETUP_CYC  = 2,
   parameter int unsigned EN_HIGH_CYC   = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_on
);

   localparam int unsigned PWR_C   = us2cyc(POWERUP_US, CLK_FREQ_HZ);
   localparam int unsigned INIT_C  = us2cyc(INIT_WAIT_US, CLK_FREQ_HZ);
   localparam int unsigned SHORT_C = us2cyc(SHORT_WAIT_US, CLK_FREQ_HZ);
   localparam int unsigned LONG_C  = us2cyc(LONG_WAIT_US, CLK_FREQ_HZ);
   localparam int unsigned M0      = PWR_C > INIT_C ? PWR_C : INIT_C;
   localparam int unsigned M1      = M0 > LONG_C ? M0 : LONG_C;
   localparam int unsigned M2      = M1 > SHORT_C ? M1 : SHORT_C;
   localparam int unsigned M3      = M2 > EN_SETUP_CYC ? M2 : EN_SETUP_CYC;
   localparam int unsigned MAX_C   = M3 > EN_HIGH_CYC ? M3 : EN_HIGH_CYC;
   localparam int unsigned TW      = $clog2(MAX_C) < 1 ? 1 : $clog2(MAX_C);

   localparam logic [TW-1:0] PWR_LD   = TW'(PWR_C - 1);
   localparam logic [TW-1:0] INIT_LD_V = TW'(INIT_C - 1);
   localparam logic [TW-1:0] SHORT_LD = TW'(SHORT_C - 1);
   localparam logic [TW-1:0] LONG_LD  = TW'(LONG_C - 1);
   localparam logic [TW-1:0] ES_LD    = TW'(EN_SETUP_CYC - 1);
   localparam logic [TW-1:0] EH_LD    = TW'(EN_HIGH_CYC - 1);

   lcd_state_e    state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          done_q, done_d;
   logic          en_q, ready_q, busy_q, on_q;
   logic          load, t_done;
   logic [TW-1:0] load_val, wait_ld;

   lcd_wait_timer #(.W(TW), .RST_VAL(PWR_LD)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .done     (t_done)
   );

   // First init 0x38 gets the long init wait; clear/home get the long wait
   always_comb begin
      wait_ld = (!done_q && idx_q == 3'd0) ? INIT_LD_V : (!rs_q && data_q[7:2] == 6'd0) ? LONG_LD : SHORT_LD;
   end

   // Next state, latched command and timer loads
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rs_d     = rs_q;
      data_d   = data_q;
      done_d   = done_q;
      load     = 1'b0;
      load_val = ES_LD;
      case (state_q)
         PWRUP:   if (t_done) state_d = INIT_LD;
         INIT_LD: begin
            state_d = SETUP;
            rs_d    = 1'b0;
            data_d  = LCD_INIT_CMD[idx_q];
            load    = 1'b1;
         end
         SETUP:   if (t_done) begin
            state_d  = PULSE;
            load     = 1'b1;
            load_val = EH_LD;
         end
         PULSE:   if (t_done) state_d = HOLD;
         HOLD:    begin
            state_d  = WAIT;
            load     = 1'b1;
            load_val = wait_ld;
         end
         WAIT:    if (t_done) begin
            if (done_q) state_d = IDLE;
            else if (idx_q == 3'd5) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = INIT_LD;
               idx_d   = idx_q + 3'd1;
            end
         end
         IDLE:    if (cmd_valid && ready_q) begin
            state_d = SETUP;
            rs_d    = cmd_rs;
            data_d  = cmd_data;
            load    = 1'b1;
         end
         default: state_d = PWRUP;
      endcase
   end

   // Outputs are registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PWRUP;
         idx_q   <= 3'd0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         done_q  <= done_d;
         en_q    <= (state_d == PULSE);
         ready_q <= (state_d == IDLE) && done_d;
         busy_q  <= (state_d != IDLE);
         on_q    <= 1'b1;
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign init_done = done_q;
   assign lcd_data  = data_q;
   assign lcd_rs    = rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_en    = en_q;
   assign lcd_on    = on_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: directed scoreboard bench for the HD44780 controller
module tb_lcd_hd44780_ctrl;

   logic       clk, rst, cmd_valid, cmd_ready, cmd_rs, busy, init_done;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_on;
   logic [7:0] cmd_data, lcd_data;

   int         errors = 0, checks = 0, cyc = 0, pulses = 0, en_w = 0, bad_io = 0;
   int         first_rise = -1, last_rise = 0;
   logic       en_prev = 1'b0;
   logic [8:0] sb [$];

   lcd_hd44780_ctrl #(
      .CLK_FREQ_HZ   (1_000_000),
      .POWERUP_US    (20),
      .INIT_WAIT_US  (10),
      .SHORT_WAIT_US (4),
      .LONG_WAIT_US  (16),
      .EN_SETUP_CYC  (2),
      .EN_HIGH_CYC   (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rs    (cmd_rs),
      .cmd_data  (cmd_data),
      .busy      (busy),
      .init_done (init_done),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_en    (lcd_en),
      .lcd_on    (lcd_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: sample at the falling edge, pop the scoreboard on every EN rise
   task automatic step();
      @(negedge clk);
      cyc++;
      if (lcd_rw !== 1'b0 || (lcd_en && (!busy || cmd_ready))) bad_io++;
      if (lcd_en && !en_prev) begin
         pulses++;
         last_rise = cyc;
         if (first_rise < 0) first_rise = cyc;
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) chk("pulse_rs_data", 32'({lcd_rs, lcd_data}), 32'(sb.pop_front()));
         en_w = 1;
      end else if (lcd_en) en_w++;
      else if (en_prev && !rst) chk("en_width", en_w, 3);
      en_prev = lcd_en;
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 100 && !cmd_ready; n++) step();
      chk("ready_timeout", 32'(cmd_ready), 32'd1);
   endtask

   task automatic push_init();
      sb.push_back(9'h038);
      sb.push_back(9'h038);
      sb.push_back(9'h038);
      sb.push_back(9'h00C);
      sb.push_back(9'h001);
      sb.push_back(9'h006);
   endtask

   // Release reset and follow the whole power-up + init sequence
   task automatic run_init();
      int en_bad = 0, rdy_bad = 0;
      pulses = 0;
      first_rise = -1;
      rst = 1'b0;
      cyc = 0;
      for (int n = 0; n < 300; n++) begin
         step();
         if (cyc == 1) chk("lcd_on_after_rst", 32'(lcd_on), 32'd1);
         if (cyc <= 20 && lcd_en) en_bad++;
         if (init_done) break;
         if (cmd_ready) rdy_bad++;
      end
      chk("init_done_cycle", cyc, 104);
      chk("pwrup_en_low", en_bad, 0);
      chk("no_ready_in_init", rdy_bad, 0);
      chk("init_pulses", pulses, 6);
      chk("first_rise", first_rise, 23);
      chk("ready_at_done", 32'(cmd_ready), 32'd1);
   endtask

   // One write; w is the expected post-command wait in cycles
   task automatic send(input logic rs, input logic [7:0] d, input int w);
      int c1;
      wait_ready();
      cmd_valid = 1'b1;
      cmd_rs    = rs;
      cmd_data  = d;
      sb.push_back({rs, d});
      step();
      cmd_valid = 1'b0;
      c1 = cyc;
      chk("ready_drop", 32'(cmd_ready), 32'd0);
      chk("latched_rs_data", 32'({lcd_rs, lcd_data}), 32'({rs, d}));
      chk("setup_en_low", 32'(lcd_en), 32'd0);
      wait_ready();
      chk("idle_latency", cyc - c1, 6 + w);
      chk("en_rise_t3", last_rise - c1, 2);
      chk("idle_hold", 32'({lcd_rs, lcd_data}), 32'({rs, d}));
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      logic [7:0] d;
      int p0;
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h55;
      repeat (3) step();
      chk("rst_lcd_en", 32'(lcd_en), 32'd0);
      chk("rst_lcd_on", 32'(lcd_on), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_lcd_data", 32'(lcd_data), 32'd0);
      chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
      chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);

      push_init();
      sb.push_back(9'h155);
      run_init();
      step();
      cmd_valid = 1'b0;
      chk("stalled_cmd_latched", 32'({lcd_rs, lcd_data}), 32'h155);
      wait_ready();
      chk("stalled_cmd_pulsed", sb.size(), 0);

      send(1'b1, 8'h41, 4);
      send(1'b0, 8'h01, 16);
      send(1'b0, 8'h02, 16);
      send(1'b0, 8'h04, 4);
      send(1'b0, 8'h03, 16);
      send(1'b1, 8'h02, 4);
      send(1'b0, 8'h80, 4);

      p0 = pulses;
      d = 8'hA1;
      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = d;
      sb.push_back({1'b1, d});
      step();
      for (int n = 0; n < 100; n++) begin
         d = d + 8'd1;
         cmd_data = d;
         step();
         if (cmd_ready) begin
            sb.push_back({1'b1, d});
            step();
            cmd_valid = 1'b0;
            break;
         end
      end
      chk("held_valid_dropped", 32'(cmd_valid), 32'd0);
      wait_ready();
      chk("held_pulse_count", pulses - p0, 2);
      chk("held_sb_drained", sb.size(), 0);

      cmd_valid = 1'b1;
      cmd_rs    = 1'b1;
      cmd_data  = 8'h77;
      sb.push_back(9'h177);
      step();
      cmd_valid = 1'b0;
      for (int n = 0; n < 20 && !lcd_en; n++) step();
      chk("pulse_seen", 32'(lcd_en), 32'd1);
      step();
      rst = 1'b1;
      step();
      chk("midrst_lcd_en", 32'(lcd_en), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("midrst_init_done", 32'(init_done), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_lcd_on", 32'(lcd_on), 32'd0);
      chk("midrst_lcd_data", 32'(lcd_data), 32'd0);
      push_init();
      run_init();
      send(1'b1, 8'h5A, 4);

      chk("io_invariants", bad_io, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
